// File: rtl/bram_rd_wr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bram_rd_wr_sched                                             |
// | Description : Single-port BRAM scheduler. Arbitrates between a loader      |
// |               write stream and a strided read-burst engine, and feeds      |
// |               read data to a valid/ready stream through a 2-entry skid     |
// |               FIFO. Optional perf counters under BRAM_SCHED_PERF_EN.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bram_rd_wr_sched #(
  parameter int DATA_W = 32,
  parameter int WR_AW  = 7,
  parameter int RD_AW  = 20,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [RD_AW-1:0]  cfg_base,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [RD_AW-1:0]  cfg_stride,
  output logic              busy,
  output logic              done,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WR_AW-1:0]  wr_addr_in,
  input  logic [DATA_W-1:0] wr_data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              bram_we,
  output logic [WR_AW-1:0]  bram_wr_addr,
  output logic [RD_AW-1:0]  bram_rd_addr,
  output logic [DATA_W-1:0] bram_data_in,
  input  logic [DATA_W-1:0] bram_data_out
`ifdef BRAM_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_conflict_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD    = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic C_GRANT_READ  = 1'b0;
  localparam logic C_GRANT_WRITE = 1'b1;

  state_t            r_state;
  logic [RD_AW-1:0]  r_rd_addr;
  logic [RD_AW-1:0]  r_stride;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issue_cnt;
  logic [LEN_W-1:0]  r_rcv_cnt;
  logic              r_inflight;
  logic              r_last_grant;
  logic              r_zero_done;
  logic [DATA_W-1:0] r_fifo_data [2];
  logic [1:0]        r_fifo_last;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic [1:0]        w_occ;
  logic              w_rd_elig;
  logic              w_wr_elig;
  logic              w_contend;
  logic              w_grant_wr;
  logic              w_grant_rd;
  logic              w_push;
  logic              w_pop;
  logic              w_start;
  logic              w_last_hs;

  // FIFO entries plus the read still in the BRAM pipeline bound how many reads may be outstanding
  assign w_occ      = r_count + {1'b0, r_inflight};
  assign w_rd_elig  = (r_state == S_RD) && (r_issue_cnt < r_len) && (w_occ < 2'd2);
  assign w_wr_elig  = wr_valid;
  assign w_contend  = w_rd_elig && w_wr_elig;
  assign w_grant_wr = w_wr_elig && (!w_rd_elig || (r_last_grant == C_GRANT_READ));
  assign w_grant_rd = w_rd_elig && (!w_wr_elig || (r_last_grant == C_GRANT_WRITE));
  assign w_push     = r_inflight;
  assign w_pop      = out_valid && out_ready;
  assign w_start    = (r_state == S_IDLE) && cfg_start;
  assign w_last_hs  = (r_state == S_DRAIN) && w_pop && out_last;

  assign busy         = (r_state != S_IDLE);
  assign done         = r_zero_done || w_last_hs;
  assign wr_ready     = w_grant_wr;
  assign bram_we      = w_grant_wr;
  assign bram_wr_addr = w_grant_wr ? wr_addr_in : '0;
  assign bram_data_in = w_grant_wr ? wr_data_in : '0;
  assign bram_rd_addr = r_rd_addr;
  assign out_valid    = (r_count != 2'd0);
  assign out_data     = r_fifo_data[r_rd_ptr];
  assign out_last     = out_valid && r_fifo_last[r_rd_ptr];

  // Burst sequencing, read address generation and round-robin history
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rd_addr    <= '0;
      r_stride     <= '0;
      r_len        <= '0;
      r_issue_cnt  <= '0;
      r_inflight   <= 1'b0;
      r_last_grant <= C_GRANT_READ;
      r_zero_done  <= 1'b0;
    end else begin
      r_zero_done <= 1'b0;
      r_inflight  <= w_grant_rd;
      if (w_contend) begin
        r_last_grant <= w_grant_wr ? C_GRANT_WRITE : C_GRANT_READ;
      end
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            if (cfg_len != '0) begin
              r_state     <= S_RD;
              r_len       <= cfg_len;
              r_stride    <= cfg_stride;
              r_rd_addr   <= cfg_base;
              r_issue_cnt <= '0;
            end else begin
              r_zero_done <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (w_grant_rd) begin
            r_rd_addr   <= r_rd_addr + r_stride;
            r_issue_cnt <= r_issue_cnt + LEN_W'(1);
            if (r_issue_cnt == r_len - LEN_W'(1)) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_last_hs) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Skid FIFO: capture registered BRAM data one cycle after each read issue
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last    <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= 2'd0;
      r_rcv_cnt      <= '0;
    end else begin
      if (w_start) begin
        r_rcv_cnt <= '0;
      end
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= bram_data_out;
        r_fifo_last[r_wr_ptr] <= (r_rcv_cnt == r_len - LEN_W'(1));
        r_wr_ptr              <= ~r_wr_ptr;
        r_rcv_cnt             <= r_rcv_cnt + LEN_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef BRAM_SCHED_PERF_EN
  // Saturating contention and output-stall counters, restarted per command
  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      perf_conflict_cnt <= '0;
      perf_stall_cnt    <= '0;
    end else begin
      if (w_contend && (perf_conflict_cnt != 32'hFFFF_FFFF)) begin
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      end
      if (out_valid && !out_ready && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_rd_wr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bram_rd_wr_sched                                          |
// | Description : Self-checking bench for bram_rd_wr_sched with a behavioural  |
// |               BRAM and a shadow-memory reference of burst contents.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bram_rd_wr_sched;

  localparam int RM_ALWAYS  = 0;
  localparam int RM_HOLD5   = 1;
  localparam int RM_RAND    = 2;
  localparam int WM_NONE    = 0;
  localparam int WM_CONTEND = 1;
  localparam int WM_RAND    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_start;
  logic [19:0] cfg_base;
  logic [15:0] cfg_len;
  logic [19:0] cfg_stride;
  logic        busy;
  logic        done;
  logic        wr_valid;
  logic        wr_ready;
  logic [6:0]  wr_addr_in;
  logic [31:0] wr_data_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        bram_we;
  logic [6:0]  bram_wr_addr;
  logic [19:0] bram_rd_addr;
  logic [31:0] bram_data_in;
  logic [31:0] bram_data_out;
`ifdef BRAM_SCHED_PERF_EN
  logic [31:0] perf_conflict_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  logic [31:0] mem     [128];
  logic [31:0] ref_mem [128];
  int          checks   = 0;
  int          failures = 0;

  bram_rd_wr_sched dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_start    (cfg_start),
    .cfg_base     (cfg_base),
    .cfg_len      (cfg_len),
    .cfg_stride   (cfg_stride),
    .busy         (busy),
    .done         (done),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr_in   (wr_addr_in),
    .wr_data_in   (wr_data_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .bram_we      (bram_we),
    .bram_wr_addr (bram_wr_addr),
    .bram_rd_addr (bram_rd_addr),
    .bram_data_in (bram_data_in),
    .bram_data_out(bram_data_out)
`ifdef BRAM_SCHED_PERF_EN
    ,
    .perf_conflict_cnt(perf_conflict_cnt),
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Single-port BRAM with registered read data, word index = byte address >> 2
  always @(posedge clk) begin
    if (bram_we) mem[bram_wr_addr] <= bram_data_in;
    bram_data_out <= mem[bram_rd_addr[8:2]];
  end

  // Hard stop in case a wait never resolves
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic int word_of(input logic [19:0] a);
    return int'(a[8:2]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic run_burst(input logic [19:0] base, input logic [19:0] stride, input int len,
                           input int rmode, input int wmode, input bit poke);
    logic [31:0] expq[$];
    bit          rset [128];
    logic [19:0] ad;
    int          got, c, nwr, conf_obs, stall_obs, a;
    bit          granted;
    for (int i = 0; i < 128; i++) rset[i] = 1'b0;
    for (int i = 0; i < len; i++) begin
      ad = base + 20'(i) * stride;
      expq.push_back(ref_mem[word_of(ad)]);
      rset[word_of(ad)] = 1'b1;
    end
    cfg_start = 1'b1; cfg_base = base; cfg_stride = stride; cfg_len = 16'(len);
    wr_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("start_idle_busy", busy, 1'b0);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    got = 0; c = 0; nwr = 0; conf_obs = 0; stall_obs = 0; granted = 1'b1;
    while (got < len && c < 200) begin
      case (rmode)
        RM_ALWAYS: out_ready = 1'b1;
        RM_HOLD5:  out_ready = (c >= 5);
        default:   out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (poke) begin
        cfg_start = (c == 3); cfg_base = 20'h00040; cfg_len = 16'd5; cfg_stride = 20'd4;
      end
      if (wmode == WM_CONTEND) begin
        wr_valid   = (nwr < 4);
        wr_addr_in = 7'(100 + nwr);
        if (granted) wr_data_in = $urandom;
      end else if (wmode == WM_RAND) begin
        if (granted || !wr_valid) begin
          a = $urandom_range(0, 127);
          for (int k = 0; k < 128 && rset[a]; k++) a = (a + 1) % 128;
          wr_valid   = ($urandom_range(0, 1) == 1);
          wr_addr_in = 7'(a);
          wr_data_in = $urandom;
        end
      end else begin
        wr_valid = 1'b0;
      end
      @(negedge clk);
      chk("we_eq_ready", bram_we, wr_ready);
      granted = wr_valid && wr_ready;
      if (granted) begin
        ref_mem[wr_addr_in] = wr_data_in;
        nwr++;
      end
      if (wmode == WM_NONE && c <= 2) chk("first_valid_lat", out_valid, (c == 2));
      if (wmode == WM_CONTEND && c < 8) begin
        chk("rr_grant", wr_ready, (c % 2 == 0));
        if (c % 2 == 1) begin
          chk("rr_rd_addr", bram_rd_addr, base + 20'(c / 2) * stride);
          chk("rr_no_we", bram_we, 1'b0);
        end
        if (wr_valid) conf_obs++;
      end
`ifdef BRAM_SCHED_PERF_EN
      if (c == 0) begin
        chk("perf_conflict_clr", perf_conflict_cnt, 0);
        chk("perf_stall_clr", perf_stall_cnt, 0);
      end
`endif
      if (out_valid && !out_ready) stall_obs++;
      if (out_valid && out_ready) begin
        chk("out_data", out_data, expq[got]);
        chk("out_last", out_last, (got == len - 1));
        chk("done_at_last", done, (got == len - 1));
        got++;
      end else begin
        chk("done_quiet", done, 1'b0);
      end
      @(posedge clk); #1;
      c++;
    end
    cfg_start = 1'b0; wr_valid = 1'b0; out_ready = 1'b1;
    chk("burst_complete", got, len);
    if (wmode == WM_CONTEND) chk("contend_writes", nwr, 4);
    @(negedge clk);
    chk("post_busy", busy, 1'b0);
    chk("post_done", done, 1'b0);
    chk("post_valid", out_valid, 1'b0);
`ifdef BRAM_SCHED_PERF_EN
    chk("perf_stall", perf_stall_cnt, stall_obs);
    if (wmode == WM_CONTEND)   chk("perf_conflict", perf_conflict_cnt, conf_obs);
    else if (wmode == WM_NONE) chk("perf_conflict_zero", perf_conflict_cnt, 0);
`endif
    @(posedge clk); #1;
    if (poke) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("poke_ignored_busy", busy, 1'b0);
        chk("poke_ignored_valid", out_valid, 1'b0);
        @(posedge clk); #1;
      end
    end
  endtask

  // Directed and randomized scenarios in sequence
  initial begin
    logic [19:0] rd_before;
    reset = 1'b1; cfg_start = 1'b0; cfg_base = '0; cfg_len = '0; cfg_stride = '0;
    wr_valid = 1'b0; wr_addr_in = '0; wr_data_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_we", bram_we, 1'b0);
    chk("rst_rd_addr", bram_rd_addr, 0);
    chk("rst_wr_addr", bram_wr_addr, 0);
    chk("rst_out_data", out_data, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Fill the whole write range, then overwrite words 0..3 with known values
    for (int a = 0; a < 132; a++) begin
      wr_valid   = 1'b1;
      wr_addr_in = (a < 128) ? 7'(a) : 7'(a - 128);
      wr_data_in = (a < 128) ? $urandom : 32'hA0 + 32'(a - 128);
      @(negedge clk);
      chk("load_wr_ready", wr_ready, 1'b1);
      if (wr_ready) ref_mem[wr_addr_in] = wr_data_in;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;

    run_burst(20'd0,   20'd4, 4, RM_ALWAYS, WM_NONE,    1'b0);
    run_burst(20'd8,   20'd8, 3, RM_HOLD5,  WM_NONE,    1'b0);
    run_burst(20'd0,   20'd4, 4, RM_ALWAYS, WM_CONTEND, 1'b0);
    run_burst(20'd400, 20'd4, 4, RM_ALWAYS, WM_NONE,    1'b0);

    // Zero-length start
    rd_before = bram_rd_addr;
    cfg_start = 1'b1; cfg_len = 16'd0; cfg_base = 20'h00100; cfg_stride = 20'd4;
    @(negedge clk);
    chk("zl_done_early", done, 1'b0);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(negedge clk);
    chk("zl_done", done, 1'b1);
    chk("zl_busy", busy, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zl_done_gone", done, 1'b0);
    chk("zl_busy2", busy, 1'b0);
    chk("zl_no_valid", out_valid, 1'b0);
    chk("zl_no_read", bram_rd_addr, rd_before);
    @(posedge clk); #1;

    run_burst(20'd16, 20'd12, 6, RM_ALWAYS, WM_NONE, 1'b1);
    run_burst(20'hFFFF8, 20'd4, 4, RM_RAND, WM_NONE, 1'b0);

    // Reset in the middle of a stalled burst
    cfg_start = 1'b1; cfg_base = 20'd0; cfg_len = 16'd8; cfg_stride = 20'd4; out_ready = 1'b0;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rmb_busy_before", busy, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rmb_busy", busy, 1'b0);
    chk("rmb_valid", out_valid, 1'b0);
    chk("rmb_we", bram_we, 1'b0);
    chk("rmb_done", done, 1'b0);
    chk("rmb_rd_addr", bram_rd_addr, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("rmb_no_done", done, 1'b0);
    end
    @(posedge clk); #1;

    for (int n = 0; n < 8; n++) begin
      run_burst(20'($urandom),
                (n % 2 == 1) ? 20'($urandom_range(0, 16) * 4) : 20'($urandom),
                $urandom_range(1, 10), n % 3,
                (n % 2 == 1) ? WM_RAND : WM_NONE, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
